// File: rtl/wg_wid_sequencer.sv
// World-Guard WID control stage: holds mlwid/slwid/mwiddeleg, legalizes CSR writes,
// drains outstanding data-memory traffic before a write commits, and registers the effective WID.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    bit          WgSMWGEn;
    bit          WgSSWGEn;
    int unsigned WG_ID_WIDTH;
    logic [31:0] WG_ID_RST_VALUE;
    logic [63:0] WG_MWID_LIST;
  } cva6_cfg_t;

  localparam cva6_cfg_t WgDefaultCfg = '{
    XLEN:            32,
    WgSMWGEn:        1'b1,
    WgSSWGEn:        1'b1,
    WG_ID_WIDTH:     4,
    WG_ID_RST_VALUE: 32'd0,
    WG_MWID_LIST:    64'hFFFF
  };
endpackage

module wg_wid_sequencer #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::WgDefaultCfg,
  parameter int unsigned           MaxOutstanding = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CVA6Cfg.WG_ID_WIDTH-1:0] mwid_i,
  input  logic [1:0]                     priv_lvl_i,
  input  logic                           csr_we_i,
  input  logic [1:0]                     csr_sel_i,
  input  logic [CVA6Cfg.XLEN-1:0]        csr_wdata_i,
  output logic [CVA6Cfg.XLEN-1:0]        csr_rdata_o,
  output logic                           csr_busy_o,
  output logic                           csr_done_o,
  input  logic                           mem_req_i,
  input  logic                           mem_rsp_i,
  output logic                           hold_issue_o,
  output logic [CVA6Cfg.WG_ID_WIDTH-1:0] wid_o,
  output logic                           err_o
);

  localparam int unsigned W    = CVA6Cfg.WG_ID_WIDTH;
  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned N    = 2 ** W;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [N-1:0]    List   = CVA6Cfg.WG_MWID_LIST[N-1:0];
  localparam logic [W-1:0]    RstWid = CVA6Cfg.WG_ID_RST_VALUE[W-1:0];
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  localparam logic [1:0] PrivM = 2'd3;
  localparam logic [1:0] PrivS = 2'd1;
  localparam logic [1:0] PrivU = 2'd0;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_e;
  typedef enum logic [1:0] {SEL_MLWID, SEL_SLWID, SEL_DELEG, SEL_NONE} sel_e;

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic [N-1:0]    wdata_q, wdata_d;
  logic [W-1:0]    mlwid_q, mlwid_d;
  logic [W-1:0]    slwid_q, slwid_d;
  logic [N-1:0]    deleg_q, deleg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [W-1:0]    wid_q, wid_d;
  logic            commit;
  logic            cnt_inc, cnt_dec;
  logic [W-1:0]    wval;

  // Only the low 2**W data bits can ever reach a register.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata_i[XLEN-1:N];

  assign cnt_inc = mem_req_i & ~mem_rsp_i;
  assign cnt_dec = mem_rsp_i & ~mem_req_i;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d = state_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (csr_we_i) begin
          sel_d   = sel_e'(csr_sel_i);
          wdata_d = csr_wdata_i[N-1:0];
          state_d = DRAIN;
        end
      end
      // A request accepted in this very cycle must also drain before the commit.
      DRAIN: if (cnt_q == '0 && !cnt_inc) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (cnt_inc) begin
      if (cnt_q == CntMax) err_d = 1'b1;
      else                 cnt_d = cnt_q + CntW'(1);
    end else if (cnt_dec) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CntW'(1);
    end
  end

  assign wval = wdata_q[W-1:0];

  always_comb begin
    mlwid_d = mlwid_q;
    slwid_d = slwid_q;
    deleg_d = deleg_q;
    if (commit) begin
      case (sel_q)
        SEL_MLWID: if (CVA6Cfg.WgSMWGEn && List[wval]) mlwid_d = wval;
        SEL_SLWID: if (CVA6Cfg.WgSSWGEn && deleg_q[wval]) slwid_d = wval;
        SEL_DELEG: deleg_d = CVA6Cfg.WgSSWGEn ? (wdata_q & List) : '0;
        default: ;
      endcase
    end
  end

  // The effective WID is taken from next-state CSRs so a commit shows up one cycle later.
  always_comb begin
    wid_d = mlwid_d;
    if (priv_lvl_i == PrivM) begin
      wid_d = mwid_i;
    end else if ((priv_lvl_i == PrivS || priv_lvl_i == PrivU) &&
                 CVA6Cfg.WgSSWGEn && deleg_d != '0) begin
      wid_d = slwid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      wdata_q <= '0;
      mlwid_q <= RstWid;
      slwid_q <= RstWid;
      deleg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wid_q   <= RstWid;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      mlwid_q <= mlwid_d;
      slwid_q <= slwid_d;
      deleg_q <= deleg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wid_q   <= wid_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_sel_i)
      2'd0:    csr_rdata_o[W-1:0] = mlwid_q;
      2'd1:    csr_rdata_o[W-1:0] = slwid_q;
      2'd2:    csr_rdata_o[N-1:0] = deleg_q;
      default: csr_rdata_o = '0;
    endcase
  end

  assign csr_busy_o   = (state_q != IDLE);
  assign csr_done_o   = (state_q == COMMIT);
  assign hold_issue_o = (state_q != IDLE) || (cnt_q == CntMax);
  assign wid_o        = wid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_wg_wid_sequencer.sv
// Bench for wg_wid_sequencer: directed scenarios plus a randomized run against a
// cycle-level reference model of the CSR write/drain rules.
module tb_wg_wid_sequencer;

  localparam config_pkg::cva6_cfg_t Cfg = '{
    XLEN:            32,
    WgSMWGEn:        1'b1,
    WgSSWGEn:        1'b1,
    WG_ID_WIDTH:     4,
    WG_ID_RST_VALUE: 32'd3,
    WG_MWID_LIST:    64'h00FF
  };
  localparam int RstWid = 3;
  localparam int ListV  = 'h00FF;
  localparam int MaxOut = 8;
  localparam int MwidV  = 'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mwid = 4'(MwidV);
  logic [1:0]  priv = 2'd0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done;
  logic        req = 1'b0;
  logic        rsp = 1'b0;
  logic        hold;
  logic [3:0]  wid;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural CSRs, outstanding count, and pending-write progress.
  int m_ml, m_sl, m_deleg, m_cnt, m_wid;
  bit m_err;
  bit m_pending, m_committing;
  int m_psel;
  int m_pdata;

  wg_wid_sequencer #(.CVA6Cfg(Cfg), .MaxOutstanding(MaxOut)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mwid_i       (mwid),
    .priv_lvl_i   (priv),
    .csr_we_i     (we),
    .csr_sel_i    (sel),
    .csr_wdata_i  (wdata),
    .csr_rdata_o  (rdata),
    .csr_busy_o   (busy),
    .csr_done_o   (done),
    .mem_req_i    (req),
    .mem_rsp_i    (rsp),
    .hold_issue_o (hold),
    .wid_o        (wid),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit inc, dec;
    int v;
    if (rst) begin
      m_ml = RstWid; m_sl = RstWid; m_deleg = 0; m_cnt = 0; m_err = 0;
      m_wid = RstWid; m_pending = 0; m_committing = 0;
      return;
    end
    inc = req && !rsp;
    dec = rsp && !req;
    if (m_committing) begin
      v = m_pdata % 16;
      if (m_psel == 0 && Cfg.WgSMWGEn && ((ListV >> v) & 1) == 1) m_ml = v;
      if (m_psel == 1 && Cfg.WgSSWGEn && ((m_deleg >> v) & 1) == 1) m_sl = v;
      if (m_psel == 2) m_deleg = Cfg.WgSSWGEn ? (m_pdata & 'hFFFF & ListV) : 0;
      m_pending = 0;
      m_committing = 0;
    end else if (m_pending) begin
      // The write commits once nothing is outstanding and nothing new was accepted.
      if (m_cnt == 0 && !inc) m_committing = 1;
    end else if (we) begin
      m_pending = 1;
      m_psel = int'(sel);
      m_pdata = int'(wdata);
    end
    if (inc) begin
      if (m_cnt == MaxOut) m_err = 1; else m_cnt++;
    end else if (dec) begin
      if (m_cnt == 0) m_err = 1; else m_cnt--;
    end
    if (priv == 2'd3) m_wid = MwidV;
    else if ((priv == 2'd1 || priv == 2'd0) && Cfg.WgSSWGEn && m_deleg != 0) m_wid = m_sl;
    else m_wid = m_ml;
  endtask

  function automatic int model_rdata(input int s);
    case (s)
      0: return m_ml;
      1: return m_sl;
      2: return m_deleg;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input bit w, input int s, input int d, input bit rq, input bit rs);
    we = w;
    sel = 2'(s);
    wdata = 32'(d);
    req = rq;
    rsp = rs;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_write(input int s, input int d, output int dones);
    bit finished = 0;
    dones = 0;
    drive(1, s, d, 0, 0);
    tick();
    for (int i = 0; i < 20 && !finished; i++) begin
      drive(0, s, 0, 0, 0);
      if (done === 1'b1) dones++;
      if (busy === 1'b0) finished = 1;
      else tick();
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL write_timeout: sel %0d still busy after 20 cycles", s);
    end
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy, done, hold, err} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, hold, err}); end
    n_cmp++; if (wid !== 4'(RstWid)) begin n_bad++;
      $display("FAIL reset_wid: got %0h expected %0h", wid, RstWid); end
    n_cmp++; if (rdata !== 32'(RstWid)) begin n_bad++;
      $display("FAIL reset_mlwid: got %0h expected %0h", rdata, RstWid); end
    drive(0, 1, 0, 0, 0);
    n_cmp++; if (rdata !== 32'(RstWid)) begin n_bad++;
      $display("FAIL reset_slwid: got %0h expected %0h", rdata, RstWid); end
    drive(0, 2, 0, 0, 0);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_deleg: got %0h expected 0", rdata); end
  endtask

  task automatic test_basic_write();
    priv = 2'd0;
    drive(1, 0, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy, done, hold} !== 3'b101) begin n_bad++;
      $display("FAIL basic_cycle1: busy/done/hold got %b expected 101", {busy, done, hold}); end
    n_cmp++; if (rdata !== 32'(RstWid)) begin n_bad++;
      $display("FAIL basic_no_early_rdata: got %0h expected %0h", rdata, RstWid); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy, done, hold} !== 3'b111) begin n_bad++;
      $display("FAIL basic_cycle2: busy/done/hold got %b expected 111", {busy, done, hold}); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy, done, hold} !== 3'b000) begin n_bad++;
      $display("FAIL basic_cycle3: busy/done/hold got %b expected 000", {busy, done, hold}); end
    n_cmp++; if (wid !== 4'd5) begin n_bad++;
      $display("FAIL basic_wid: got %0h expected 5", wid); end
    n_cmp++; if (rdata !== 32'd5) begin n_bad++;
      $display("FAIL basic_rdata: got %0h expected 5", rdata); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 0); tick(); end
    drive(1, 0, 6, 0, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, i <= 3);
      n_cmp++; if ({busy, done, hold} !== 3'b101) begin n_bad++;
        $display("FAIL drain_cycle%0d: busy/done/hold got %b expected 101", i, {busy, done, hold}); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({done, hold} !== 2'b11) begin n_bad++;
      $display("FAIL drain_commit: done/hold got %b expected 11", {done, hold}); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (wid !== 4'd6 || busy !== 1'b0) begin n_bad++;
      $display("FAIL drain_result: wid/busy got %0h/%b expected 6/0", wid, busy); end
  endtask

  task automatic test_illegal();
    int dones;
    run_write(0, 9, dones);
    n_cmp++; if (dones !== 1) begin n_bad++;
      $display("FAIL illegal_ml_done: got %0d pulses expected 1", dones); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (rdata !== 32'd6) begin n_bad++;
      $display("FAIL illegal_ml_kept: got %0h expected 6", rdata); end
    run_write(2, 'hFFFF, dones);
    drive(0, 2, 0, 0, 0);
    n_cmp++; if (rdata !== 32'h00FF) begin n_bad++;
      $display("FAIL deleg_masked: got %0h expected ff", rdata); end
  endtask

  task automatic test_delegation();
    int dones;
    run_write(2, 'h0004, dones);
    run_write(1, 2, dones);
    drive(0, 1, 0, 0, 0);
    n_cmp++; if (rdata !== 32'd2) begin n_bad++;
      $display("FAIL slwid_accept: got %0h expected 2", rdata); end
    priv = 2'd1; tick(); drive(0, 1, 0, 0, 0);
    n_cmp++; if (wid !== 4'd2) begin n_bad++;
      $display("FAIL s_mode_wid: got %0h expected 2", wid); end
    priv = 2'd3; tick(); drive(0, 1, 0, 0, 0);
    n_cmp++; if (wid !== 4'(MwidV)) begin n_bad++;
      $display("FAIL m_mode_wid: got %0h expected %0h", wid, MwidV); end
    priv = 2'd0;
    run_write(1, 3, dones);
    drive(0, 1, 0, 0, 0);
    n_cmp++; if (rdata !== 32'd2) begin n_bad++;
      $display("FAIL slwid_reject: got %0h expected 2", rdata); end
    n_cmp++; if (wid !== 4'd2) begin n_bad++;
      $display("FAIL u_mode_deleg_wid: got %0h expected 2", wid); end
  endtask

  task automatic test_counter();
    do_reset();
    for (int i = 0; i < MaxOut; i++) begin drive(0, 0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 1, 1);
    n_cmp++; if ({hold, err} !== 2'b10) begin n_bad++;
      $display("FAIL cnt_full: hold/err got %b expected 10", {hold, err}); end
    tick();
    drive(0, 0, 0, 1, 0);
    n_cmp++; if ({hold, err} !== 2'b10) begin n_bad++;
      $display("FAIL cnt_both: hold/err got %b expected 10", {hold, err}); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({hold, err} !== 2'b11) begin n_bad++;
      $display("FAIL cnt_overflow: hold/err got %b expected 11", {hold, err}); end
    do_reset();
    drive(0, 0, 0, 0, 1);
    n_cmp++; if (err !== 1'b0) begin n_bad++;
      $display("FAIL err_cleared: got %b expected 0", err); end
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({hold, err} !== 2'b01) begin n_bad++;
      $display("FAIL cnt_underflow: hold/err got %b expected 01", {hold, err}); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0); tick(); end
    drive(1, 0, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL midrst_drain: busy got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      n_cmp++; if ({busy, done, hold, err} !== 4'b0) begin n_bad++;
        $display("FAIL midrst_flags%0d: got %b expected 0000", i, {busy, done, hold, err}); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (rdata !== 32'(RstWid) || wid !== 4'(RstWid)) begin n_bad++;
      $display("FAIL midrst_regs: rdata/wid got %0h/%0h expected %0h", rdata, wid, RstWid); end
  endtask

  task automatic test_random();
    int prv_tab[4] = '{0, 1, 3, 2};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit w, rq, rs;
      int s, d;
      w  = ($urandom_range(0, 3) == 0);
      s  = $urandom_range(0, 3);
      d  = $urandom_range(0, 65535);
      rq = ($urandom_range(0, 9) < 4);
      rs = (m_cnt > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) priv = 2'(prv_tab[$urandom_range(0, 3)]);
      drive(w, s, d, rq, rs);
      n_cmp++; if (busy !== m_pending || done !== m_committing) begin n_bad++;
        $display("FAIL rnd_busy_done c%0d: got %b%b expected %b%b", c, busy, done, m_pending, m_committing); end
      n_cmp++; if (hold !== (m_pending || m_cnt == MaxOut)) begin n_bad++;
        $display("FAIL rnd_hold c%0d: got %b expected %b", c, hold, m_pending || m_cnt == MaxOut); end
      n_cmp++; if (wid !== 4'(m_wid) || err !== m_err) begin n_bad++;
        $display("FAIL rnd_wid_err c%0d: got %0h/%b expected %0h/%b", c, wid, err, m_wid, m_err); end
      n_cmp++; if (rdata !== 32'(model_rdata(s))) begin n_bad++;
        $display("FAIL rnd_rdata c%0d sel%0d: got %0h expected %0h", c, s, rdata, model_rdata(s)); end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_drain();
    test_illegal();
    test_delegation();
    test_counter();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
